// File: rtl/osc_model_pkg.sv
// Shared types and helpers for the variable-period emulated oscillator.
// OSC_RAND_JITTER_EN selects the LFSR jitter variant of the oscillator.
package osc_model_pkg;

  localparam int DT_WIDTH = 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [DT_WIDTH-1:0] dt_t;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  function automatic dt_t clamp_dt(input dt_t x, input dt_t min);
    return (x < min) ? min : x;
  endfunction

endpackage

// File: rtl/osc_lfsr16.sv
// 16-bit Galois LFSR used as the jitter source; only built when
// OSC_RAND_JITTER_EN is defined.
`ifdef OSC_RAND_JITTER_EN
module osc_lfsr16
  import osc_model_pkg::*;
(
  input  logic        emu_clk,
  input  logic        emu_rst,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule
`endif

// File: rtl/osc_model_var.sv
// Emulated variable-period clock generator driven by granted timesteps.
// Define OSC_RAND_JITTER_EN to add 0..3 units of LFSR jitter per reload.
module osc_model_var
  import osc_model_pkg::*;
#(
  parameter int DT_WIDTH = osc_model_pkg::DT_WIDTH,
  parameter int MIN_DT   = 1
) (
  input  logic                emu_clk,
  input  logic                emu_rst,
  input  logic [DT_WIDTH-1:0] t_lo,
  input  logic [DT_WIDTH-1:0] t_hi,
  input  logic [DT_WIDTH-1:0] emu_dt,
  input  logic                emu_stall,
  output logic [DT_WIDTH-1:0] dt_req,
  output logic                clk_val,
  output logic                cke,
  output logic                err
);

  localparam dt_t MIN_DT_V = dt_t'(MIN_DT);

  phase_t phase_q, phase_d;
  dt_t    rem_q, rem_d;
  logic   err_q, err_d;

  dt_t    lo_dur;
  dt_t    hi_dur;
  logic   advance;
  logic   transition;

`ifdef OSC_RAND_JITTER_EN
  logic [15:0] lfsr_val;

  osc_lfsr16 u_lfsr (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .adv     (transition && !emu_rst),
    .q       (lfsr_val)
  );

  // Floor first, then jitter, so jitter can never be masked by the clamp
  assign lo_dur = clamp_dt(t_lo, MIN_DT_V) + dt_t'(lfsr_val[1:0]);
  assign hi_dur = clamp_dt(t_hi, MIN_DT_V) + dt_t'(lfsr_val[1:0]);
`else
  assign lo_dur = clamp_dt(t_lo, MIN_DT_V);
  assign hi_dur = clamp_dt(t_hi, MIN_DT_V);
`endif

  assign advance    = !emu_stall && (emu_dt != '0);
  assign transition = advance && (emu_dt >= rem_q);

  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (transition) begin
      // Overshoot is flagged but the excess is dropped, not carried over
      if (emu_dt > rem_q) begin
        err_d = 1'b1;
      end
      if (phase_q == PH_LOW) begin
        phase_d = PH_HIGH;
        rem_d   = hi_dur;
      end else begin
        phase_d = PH_LOW;
        rem_d   = lo_dur;
      end
    end else if (advance) begin
      rem_d = rem_q - emu_dt;
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      phase_q <= PH_LOW;
      rem_q   <= clamp_dt(t_lo, MIN_DT_V);
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign dt_req  = rem_q;
  assign clk_val = (phase_q == PH_HIGH);
  assign err     = err_q;
  assign cke     = !emu_rst && transition && (phase_q == PH_LOW);

endmodule

// File: tb/tb_osc_model_var.sv
// Self-checking bench for osc_model_var (default build, no jitter):
// directed scenarios plus randomized timesteps against a behavioural model.
module tb_osc_model_var;

  logic        clk;
  logic        rst;
  logic [31:0] t_lo;
  logic [31:0] t_hi;
  logic [31:0] emu_dt;
  logic        emu_stall;
  logic [31:0] dt_req;
  logic        clk_val;
  logic        cke;
  logic        err;

  int vectors;
  int miscompares;

  // Reference model: the oscillator level, time left until its next edge, sticky overshoot
  bit              m_high;
  longint unsigned m_left;
  bit              m_err;

  osc_model_var dut (
    .emu_clk   (clk),
    .emu_rst   (rst),
    .t_lo      (t_lo),
    .t_hi      (t_hi),
    .emu_dt    (emu_dt),
    .emu_stall (emu_stall),
    .dt_req    (dt_req),
    .clk_val   (clk_val),
    .cke       (cke),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic longint unsigned floorDur(input logic [31:0] x);
    return (x == 0) ? 64'd1 : 64'(x);
  endfunction

  // Drive one emu_clk cycle, check against the model mid-cycle, then advance the model
  task automatic applyStimulus(input bit r, input bit stall, input logic [31:0] dt,
                               input logic [31:0] lo, input logic [31:0] hi);
    bit exp_cke;
    rst       = r;
    emu_stall = stall;
    emu_dt    = dt;
    t_lo      = lo;
    t_hi      = hi;
    @(negedge clk);
    exp_cke = !r && !stall && (dt != 0) && !m_high && (64'(dt) >= m_left);
    checkOutput("cke", 64'(cke), 64'(exp_cke));
    checkOutput("dt_req", 64'(dt_req), m_left);
    checkOutput("clk_val", 64'(clk_val), 64'(m_high));
    checkOutput("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (r) begin
      m_high = 1'b0;
      m_left = floorDur(lo);
      m_err  = 1'b0;
    end else if (!stall && dt != 0) begin
      if (64'(dt) < m_left) begin
        m_left = m_left - 64'(dt);
      end else begin
        if (64'(dt) > m_left) m_err = 1'b1;
        m_high = !m_high;
        m_left = m_high ? floorDur(hi) : floorDur(lo);
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] dt;
    logic [31:0] lo;
    logic [31:0] hi;
    int kick;
    vectors     = 0;
    miscompares = 0;
    m_high = 1'b0;
    m_left = 64'd123;
    m_err  = 1'b0;
    rst = 1'b1; emu_stall = 1'b0; emu_dt = 32'd0; t_lo = 32'd123; t_hi = 32'd234;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_dt_req", 64'(dt_req), 64'd123);
    checkOutput("reset_clk_val", 64'(clk_val), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);

    // Grant exactly the request every cycle: toggles every cycle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'(m_left), 32'd123, 32'd234);
      checkOutput("full_dt_req", 64'(dt_req), (i % 2 == 0) ? 64'd234 : 64'd123);
      checkOutput("full_clk_val", 64'(clk_val), (i % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Partial steps 123 -> 73 -> 23, then exact finish
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd123, 32'd234);
    applyStimulus(1'b0, 1'b0, 32'd50, 32'd123, 32'd234);
    checkOutput("part_73", 64'(dt_req), 64'd73);
    applyStimulus(1'b0, 1'b0, 32'd50, 32'd123, 32'd234);
    checkOutput("part_23", 64'(dt_req), 64'd23);
    applyStimulus(1'b0, 1'b0, 32'd23, 32'd123, 32'd234);
    checkOutput("part_rise", 64'(clk_val), 64'd1);
    checkOutput("part_hi", 64'(dt_req), 64'd234);

    // Stall blocks an otherwise exact transition
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd123, 32'd234);
    applyStimulus(1'b0, 1'b1, 32'd123, 32'd123, 32'd234);
    checkOutput("stall_hold", 64'(clk_val), 64'd0);
    checkOutput("stall_rem", 64'(dt_req), 64'd123);
    applyStimulus(1'b0, 1'b0, 32'd123, 32'd123, 32'd234);
    checkOutput("stall_release", 64'(clk_val), 64'd1);

    // Overshoot sets a sticky error; t_hi=0 floors to 1
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd20, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd30, 32'd20, 32'd0);
    checkOutput("ovr_err", 64'(err), 64'd1);
    checkOutput("min_dt", 64'(dt_req), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd50, 32'd0);
    checkOutput("lo_resample", 64'(dt_req), 64'd50);
    checkOutput("ovr_sticky", 64'(err), 64'd1);

    // Reset mid-HIGH discards remaining time and clears the error
    applyStimulus(1'b0, 1'b0, 32'd50, 32'd50, 32'd100);
    checkOutput("mid_high_rem", 64'(dt_req), 64'd100);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd77, 32'd100);
    checkOutput("rst_clk_val", 64'(clk_val), 64'd0);
    checkOutput("rst_dt_req", 64'(dt_req), 64'd77);
    checkOutput("rst_err", 64'(err), 64'd0);

    // Randomized timesteps, durations, stalls and resets
    for (int i = 0; i < 500; i++) begin
      lo = 32'($urandom_range(0, 30));
      hi = 32'($urandom_range(0, 30));
      kick = int'($urandom_range(0, 5));
      case (kick)
        0: dt = 32'd0;
        1: dt = 32'(m_left);
        2: dt = (m_left > 1) ? 32'($urandom_range(1, 32'(m_left - 1))) : 32'(m_left);
        3: dt = 32'(m_left) + 32'($urandom_range(1, 5));
        4: dt = 32'($urandom_range(0, 40));
        default: dt = 32'(m_left);
      endcase
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, dt, lo, hi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/osc_model_var.md
Name: osc_model_var

Overview:
- Emulated variable-period clock generator. Consumes the t_lo/t_hi durations (32-bit, DT_SCALE units) that the simulation controller drives.
- Produces the emulated clock value, a rising-edge clock enable, and a timestep request to the emulator's time manager.
- Sits between the controller and the DUT: its clk_val output is the clk_i the controller checks.

Parameters:
- DT_WIDTH, 32, width of durations, timestep request and grant.
- MIN_DT, 1, floor applied to any sampled duration, so a 0 duration never stalls time.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst  in  1  synchronous active-high reset.
- t_lo  in  DT_WIDTH  low-phase duration, DT_SCALE units.
- t_hi  in  DT_WIDTH  high-phase duration, DT_SCALE units.
- emu_dt  in  DT_WIDTH  timestep granted this emu_clk cycle (global min of all requests).
- emu_stall  in  1  when high, no emulated time passes this cycle.
- dt_req  out  DT_WIDTH  time remaining until this oscillator's next edge.
- clk_val  out  1  emulated clock level.
- cke  out  1  high during the emu_clk cycle whose rising edge performs the low->high transition.
- err  out  1  sticky overshoot flag.

Behaviour:
- Interface: one clock, emu_clk; reset emu_rst is synchronous, active-high. All state updates on the rising edge of emu_clk.
- Phases: LOW and HIGH; clk_val = (phase == HIGH).
- Registered state: phase, rem (remaining duration), err.
- dt_req = rem, registered, zero combinational path from emu_dt.
- Duration sampling: dur(x) = (x < MIN_DT) ? MIN_DT : x. Sampled only at reset and at each transition; mid-phase changes to t_lo/t_hi have no effect until the next transition.
- Reset (emu_rst=1 at an edge):
  - phase = LOW, clk_val = 0, rem = dur(t_lo), err = 0.
  - Reset wins over all other inputs.
  - Reset asserted mid-phase discards rem.
- Per edge, when emu_rst=0:
  - emu_stall=1: no change, even if emu_dt is nonzero.
  - emu_dt == 0: no change.
  - 0 < emu_dt < rem: rem <= rem - emu_dt, no wrap possible.
  - emu_dt == rem: transition. Phase toggles. rem <= dur(t_hi) when entering HIGH, dur(t_lo) when entering LOW.
  - emu_dt > rem: same transition as emu_dt == rem, and err <= 1. Excess time is discarded, not carried into the new phase.
- cke = !emu_rst && !emu_stall && (phase == LOW) && (emu_dt >= rem) && (emu_dt != 0).
  - Combinational.
  - One emu_clk cycle wide per rising transition.
  - Never high in two consecutive cycles, because rem >= MIN_DT >= 1 after a reload.
- Latency: clk_val changes on the same emu_clk edge at which cke is high. The new dt_req is valid the cycle after.
- Arithmetic: unsigned DT_WIDTH throughout, no saturation required.

Optional Feature:
- Macro: OSC_RAND_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances at each transition.
  - The reloaded duration becomes dur(x) + lfsr[1:0], i.e. 0..3 units of added jitter.
  - The floor is still applied before the addition.
- Undefined: no LFSR is present and durations are exact.

Decomposition:
- Package osc_model_pkg:
  - dt_t = logic [DT_WIDTH-1:0], with a DT_WIDTH default of 32.
  - phase_t enum {PH_LOW, PH_HIGH}.
  - localparam LFSR_SEED.
  - function clamp_dt(x, min).
- Sub-module: osc_lfsr16, present only under OSC_RAND_JITTER_EN, with ports emu_clk, emu_rst, adv, q[15:0]. Everything else stays flat.

Test Plan:
- Reset, then t_lo=123, t_hi=234, emu_dt=dt_req every cycle -> dt_req alternates 123/234, clk_val toggles every cycle, cke high on every second cycle, err=0.
- t_lo=123, emu_dt=50 repeatedly -> dt_req sequence 123,73,23. With emu_dt=23 -> clk_val rises and cke=1 in that cycle, then dt_req=234.
- emu_stall=1 with emu_dt=123 at rem=123 -> no transition and cke=0. On deassert -> transition occurs.
- rem=20, emu_dt=30 -> transition, err=1 and stays 1 until emu_rst.
- t_hi=0 sampled at the rising transition -> dt_req=1 (MIN_DT). Change t_lo mid-HIGH from 123 to 50 -> the next LOW phase is 50.
- emu_rst asserted while in HIGH with rem=100 -> next cycle clk_val=0, dt_req=dur(t_lo), err=0.
